// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; aligns/extends SRAM load data and keeps it
// stable across stalls, feeding both the write-back bus and the forwarding path.
module mem_stage #(
    parameter int IN_WD  = 79,
    parameter int OUT_WD = 70
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [5:0]        stall,
    input  logic [IN_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]       data_sram_rdata,
    output logic [OUT_WD-1:0] mem_to_wb_bus,
    output logic [37:0]       mem_to_id
);
    logic [IN_WD-1:0] bus_r;
    logic             first_cyc;
    logic [31:0]      rdata_hold;
    logic [31:0]      pc;
    logic [2:0]       mem_op;
    logic             data_ram_en;
    logic [3:0]       data_ram_wen;
    logic             sel_rf_res;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      ex_result;
    logic             is_load;
    logic [31:0]      word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic [31:0]      rf_wdata;
    logic             unused_stall;

    assign {pc, mem_op, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = bus_r;
    assign is_load      = data_ram_en && data_ram_wen == 4'b0000;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r      <= '0;
            first_cyc  <= 1'b0;
            rdata_hold <= '0;
        end else begin
            if (first_cyc && is_load)
                rdata_hold <= data_sram_rdata;
            if (stall[3] && !stall[4]) begin
                bus_r     <= '0;
                first_cyc <= 1'b1;
            end else if (!stall[3]) begin
                bus_r     <= ex_to_mem_bus;
                first_cyc <= 1'b1;
            end else begin
                first_cyc <= 1'b0;
            end
        end
    end

    // SRAM output is only valid the cycle after the request; later cycles use the captured copy
    assign word    = first_cyc ? data_sram_rdata : rdata_hold;
    assign ld_byte = word[{ex_result[1:0], 3'b000} +: 8];
    assign ld_half = ex_result[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = mem_op == 3'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                  mem_op == 3'd2 ? {24'b0, ld_byte} :
                  mem_op == 3'd3 ? {{16{ld_half[15]}}, ld_half} :
                  mem_op == 3'd4 ? {16'b0, ld_half} : word;
    end

    assign rf_wdata      = sel_rf_res ? ld_data : ex_result;
    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id     = {rf_we, rf_waddr, rf_wdata};
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have the parameter IN_WD, default 79, giving the width of ex_to_mem_bus.
REQ-002 The module SHALL have the parameter OUT_WD, default 70, giving the width of mem_to_wb_bus.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port stall, input, 6 bits: the pipeline stall vector; Stop=1; bit 3 is this stage's input register and bit 4 is the downstream register.
REQ-006 Port ex_to_mem_bus, input, IN_WD bits: pc[78:47], mem_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
REQ-007 Port data_sram_rdata, input, 32 bits: the SRAM read word, valid in the first cycle after the request.
REQ-008 Port mem_to_wb_bus, output, OUT_WD bits: pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].
REQ-009 Port mem_to_id, output, 38 bits: the forwarding path, {rf_we, rf_waddr, rf_wdata}.

Function
REQ-010 The input register SHALL clear to zero (bubble) when stall[3]=Stop and stall[4]=NoStop.
REQ-011 Otherwise, when stall[3]=NoStop, the input register SHALL load ex_to_mem_bus.
REQ-012 In all other cases the input register SHALL hold its value.
REQ-013 A register first_cyc SHALL be set to 1 on every load or bubble of the input register, and cleared to 0 on any clock edge where the register holds.
REQ-014 A load SHALL be defined as data_ram_en=1 and data_ram_wen=4'b0000.
REQ-015 A 32-bit register rdata_hold SHALL capture data_sram_rdata on each edge where first_cyc=1 and the instruction is a load; otherwise it holds.
REQ-016 The effective read word SHALL be data_sram_rdata when first_cyc=1, else rdata_hold, so a stalled load keeps its data after the SRAM output changes.
REQ-017 Load data selection, mem_op 000 (LW): the effective word is used unchanged; addr[1:0] is ignored.
REQ-018 Load data selection, mem_op 001 (LB) / 010 (LBU): the byte is chosen by ex_result[1:0] (00 selects bits 7:0, 11 selects bits 31:24), then sign-extended (LB) or zero-extended (LBU).
REQ-019 Load data selection, mem_op 011 (LH) / 100 (LHU): the halfword is chosen by ex_result[1] (0 selects 15:0, 1 selects 31:16); ex_result[0] is ignored; then sign-extended (LH) or zero-extended (LHU).
REQ-020 mem_op 101–111 SHALL be treated as LW.
REQ-021 rf_wdata SHALL equal the selected load data when sel_rf_res=1, else ex_result.
REQ-022 pc, rf_we and rf_waddr SHALL pass from the input register to both output buses unchanged.
REQ-023 Both outputs SHALL be purely combinational from the register state, with zero added latency: a result is visible in the same cycle its instruction occupies MEM.
REQ-024 A bubble SHALL produce rf_we=0 on both output buses.
REQ-025 A non-load instruction SHALL neither use nor update rdata_hold.
REQ-026 Store instructions (wen≠0) with sel_rf_res=0 SHALL forward ex_result with their own rf_we, normally 0.

Reset
REQ-027 While resetn=0, the input register, rdata_hold and first_cyc SHALL all be 0, asynchronously and regardless of clk or stall.
REQ-028 Consequently, while resetn=0 and after it deasserts, both output buses SHALL read all-zero until the first load or bubble of the input register.
REQ-029 Deasserting resetn mid-stall SHALL leave the stage empty; no held load data survives reset.
REQ-030 Reset SHALL take priority over the stall controls.

Verification
REQ-031 Scenario LB: bus with mem_op=001, ex_result=0x00001003, sel_rf_res=1, rf_we=1, waddr=5, then rdata=0x80FF7F01 -> mem_to_wb rf_wdata=0xFFFFFF80, waddr=5, rf_we=1.
REQ-032 Scenario LHU at addr[1]=1: rdata=0x8001_1234 -> rf_wdata=0x00008001; the same with LH -> 0xFFFF8001.
REQ-033 Scenario stalled load: LW loaded, rdata=0xDEADBEEF in the first cycle, stall[4:3]=11 for 3 cycles while rdata changes to 0x0 -> rf_wdata stays 0xDEADBEEF throughout.
REQ-034 Scenario bubble insertion: stall[4:3]=01 -> next cycle mem_to_wb and mem_to_id show rf_we=0 and waddr=0.
REQ-035 Scenario ALU pass-through: sel_rf_res=0, ex_result=0x12345678, rf_we=1, waddr=31 -> mem_to_id={1,31,0x12345678} in the same cycle.
REQ-036 Scenario async reset mid-operation: a load is held under stall and resetn is pulsed low between edges -> outputs go to zero immediately, and rdata_hold reads 0 on the next load check.
